// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: the NOP payload,
// the ID/EX control-bundle field layout and the occupancy-width helper.
package pipe_pkg;

   // All-zero payload: every control bit cleared is a NOP downstream.
   localparam logic [255:0] NOP_PAYLOAD = '0;

   // ID/EX control bundle layout inside in_data (LSB first).
   localparam int MEM_WRITE_BIT    = 0;
   localparam int MEM_READ_BIT     = 1;
   localparam int REG_WRITE_BIT    = 2;
   localparam int REG_DEST_LSB     = 3;
   localparam int REG_DEST_W       = 2;
   localparam int ALU_CONTROL_LSB  = 5;
   localparam int ALU_CONTROL_W    = 4;
   localparam int ALU_SRC_BIT      = 9;
   localparam int BRANCH_BIT       = 10;
   localparam int MEM_TO_REG_BIT   = 11;
   localparam int CTRL_WIDTH       = 12;

   // Bits needed to count 0..depth valid stages.
   function automatic int occWidth(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One valid+data pipeline register with reset > flush > stall > load priority.
// A stage never holds a non-bubble payload while its valid bit is clear.
module pipe_stage_cell import pipe_pkg::*; #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = NOP_PAYLOAD[WIDTH-1:0]
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             inValid,
   input  logic [WIDTH-1:0] inData,
   output logic             outValid,
   output logic [WIDTH-1:0] outData
);

   // Synchronous reset, then flush, then hold, else capture (masking invalid data).
   always_ff @(posedge clk) begin
      if (!rst) begin
         outValid <= 1'b0;
         outData  <= BUBBLE_VAL;
      end else if (flush) begin
         outValid <= 1'b0;
         outData  <= BUBBLE_VAL;
      end else if (!stall) begin
         outValid <= inValid;
         outData  <= inValid ? inData : BUBBLE_VAL;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH cells in series sharing
// stall/flush, plus a registered count of valid stages.
module pipe_stage_reg import pipe_pkg::*; #(
   parameter int               WIDTH      = 32,
   parameter int               DEPTH      = 1,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = NOP_PAYLOAD[WIDTH-1:0]
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         stall,
   input  logic                         flush,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   output logic [occWidth(DEPTH)-1:0]   occupancy,
   output logic                         in_ready
);

   localparam int OCC_W = occWidth(DEPTH);

   logic             stageValid [DEPTH];
   logic [WIDTH-1:0] stageData  [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             cellInValid;
      logic [WIDTH-1:0] cellInData;

      if (i == 0) begin : g_head
         assign cellInValid = in_valid;
         assign cellInData  = in_data;
      end else begin : g_body
         assign cellInValid = stageValid[i-1];
         assign cellInData  = stageData[i-1];
      end

      pipe_stage_cell #(
         .WIDTH      (WIDTH),
         .BUBBLE_VAL (BUBBLE_VAL)
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .stall    (stall),
         .flush    (flush),
         .inValid  (cellInValid),
         .inData   (cellInData),
         .outValid (stageValid[i]),
         .outData  (stageData[i])
      );
   end

   // Occupancy tracks the valid popcount: one enters at the head, one leaves at the tail.
   always_ff @(posedge clk) begin
      if (!rst) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else if (!stall) begin
         occupancy <= occupancy + OCC_W'(in_valid) - OCC_W'(stageValid[DEPTH-1]);
      end
   end

   assign out_valid = stageValid[DEPTH-1];
   assign out_data  = stageData[DEPTH-1];
   assign in_ready  = ~stall;

endmodule
